// File: rtl/puck_ctrl_defs.sv
// rtl/puck_ctrl_defs.sv - shared constants, state encoding and helpers for puck_ctrl
package puck_ctrl_defs;

    // Playfield geometry in hc/vc screen space
    localparam logic [9:0]  X_MIN       = 10'd194;
    localparam logic [9:0]  X_MAX       = 10'd737;
    localparam logic [9:0]  Y_MIN       = 10'd71;
    localparam logic [9:0]  Y_MAX       = 10'd473;
    localparam logic [9:0]  GOAL_LO     = 10'd222;
    localparam logic [9:0]  GOAL_HI     = 10'd322;
    localparam logic [9:0]  R_PUCK      = 10'd10;
    // Squared contact radius between puck and paddle centres
    localparam logic [20:0] HIT_R2      = 21'd625;
    localparam logic [3:0]  WIN_SCORE   = 4'd7;
    localparam logic [4:0]  SERVE_TICKS = 5'd30;
    localparam logic [3:0]  SERVE_DX    = 4'd3;
    localparam logic [3:0]  SERVE_DY    = 4'd2;

    typedef enum logic [3:0] {
        IDLE, SERVE, PLAY, WALL, P1X, P1Y, P2X, P2Y, COMMIT, GOAL, OVER
    } state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/puck_ctrl_if.sv
// rtl/puck_ctrl_if.sv - strobes, coordinates and mover/score outputs of puck_ctrl
// Ports of the slave (controller) side:
//   in : tick, start, puck_x/y, dot_x_1/y_1, dot_x_2/y_2
//   out: delta_x/y, dir_x/y, puck_reset, score_1/2, hit_1/2, game_over, busy, overrun
interface puck_ctrl_if;
    logic       tick;
    logic       start;
    logic [9:0] puck_x;
    logic [9:0] puck_y;
    logic [9:0] dot_x_1;
    logic [9:0] dot_y_1;
    logic [9:0] dot_x_2;
    logic [9:0] dot_y_2;
    logic [3:0] delta_x;
    logic [3:0] delta_y;
    logic       dir_x;
    logic       dir_y;
    logic       puck_reset;
    logic [3:0] score_1;
    logic [3:0] score_2;
    logic       hit_1;
    logic       hit_2;
    logic       game_over;
    logic       busy;
    logic       overrun;

    modport master (
        output tick, start, puck_x, puck_y, dot_x_1, dot_y_1, dot_x_2, dot_y_2,
        input  delta_x, delta_y, dir_x, dir_y, puck_reset, score_1, score_2,
               hit_1, hit_2, game_over, busy, overrun
    );

    modport slave (
        input  tick, start, puck_x, puck_y, dot_x_1, dot_y_1, dot_x_2, dot_y_2,
        output delta_x, delta_y, dir_x, dir_y, puck_reset, score_1, score_2,
               hit_1, hit_2, game_over, busy, overrun
    );
endinterface

// File: rtl/puck_ctrl_abs_square.sv
// rtl/puck_ctrl_abs_square.sv - combinational |a-b| and its 20-bit square
// Ports: a, b (10-bit unsigned) in; sq (20-bit unsigned) out.
module abs_square (
    input  logic [9:0]  a,
    input  logic [9:0]  b,
    output logic [19:0] sq
);
    logic [9:0] diff;

    // Subtract the smaller from the larger so the difference never wraps
    assign diff = (a >= b) ? (a - b) : (b - a);
    assign sq   = {10'd0, diff} * {10'd0, diff};
endmodule

// File: rtl/puck_ctrl.sv
// rtl/puck_ctrl.sv - air-hockey puck controller: serve, walls, paddles, goals, score
// Ports: clk, clr_n (async active-low), bus (puck_ctrl_if.slave: tick/start and
//        coordinates in; speed, direction, recentre, score, hit and status out).
module puck_ctrl
    import puck_ctrl_defs::*;
(
    input  logic         clk,
    input  logic         clr_n,
    puck_ctrl_if.slave   bus
);
    // Wall thresholds rearranged so no subtraction can wrap below zero
    localparam logic [9:0] X_LEFT   = X_MIN + R_PUCK;
    localparam logic [9:0] X_RIGHT  = X_MAX - R_PUCK;
    localparam logic [9:0] Y_TOP    = Y_MIN + R_PUCK;
    localparam logic [9:0] Y_BOT    = Y_MAX - R_PUCK;
    localparam logic [4:0] SERVE_LAST = SERVE_TICKS - 5'd1;

    state_t      state, state_n;
    logic [9:0]  sx, sy, s1x, s1y, s2x, s2y;
    logic [20:0] acc;
    logic [9:0]  sq_a, sq_b;
    logic [19:0] sq;
    logic [20:0] dist2;
    logic        contact;
    logic [3:0]  delta_x, delta_y, score_1, score_2;
    logic [3:0]  pend_dx, pend_dy;
    logic        dir_x, dir_y, pend_dir_x, pend_dir_y, pend_h1, pend_h2;
    logic        puck_reset, hit_1, hit_2, overrun, concede_2;
    logic [4:0]  serve_cnt;
    logic        busy, in_goal, left_touch, right_touch, goal_l, goal_r, win;

    assign busy        = state inside {WALL, P1X, P1Y, P2X, P2Y, COMMIT};
    assign in_goal     = (sy >= GOAL_LO) && (sy <= GOAL_HI);
    assign left_touch  = sx <= X_LEFT;
    assign right_touch = sx >= X_RIGHT;
    assign goal_l      = left_touch && in_goal;
    assign goal_r      = right_touch && in_goal;
    assign win         = (score_1 == WIN_SCORE) || (score_2 == WIN_SCORE);
    assign dist2       = acc + {1'b0, sq};
    assign contact     = dist2 < HIT_R2;

    // One squarer, stepped through the four coordinate pairs
    always_comb begin
        sq_a = sx;
        sq_b = s1x;
        case (state)
            P1Y:     begin sq_a = sy; sq_b = s1y; end
            P2X:     begin sq_a = sx; sq_b = s2x; end
            P2Y:     begin sq_a = sy; sq_b = s2y; end
            default: ;
        endcase
    end

    abs_square u_sq (.a(sq_a), .b(sq_b), .sq(sq));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_n;
    end

    // The P2 states are always walked so the commit latency is fixed; a paddle 1
    // contact only suppresses the paddle 2 result.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, OVER: if (bus.start) state_n = SERVE;
            SERVE:      if (bus.tick && serve_cnt == SERVE_LAST) state_n = PLAY;
            PLAY:       if (bus.tick) state_n = WALL;
            WALL:       state_n = (goal_l || goal_r) ? GOAL : P1X;
            P1X:        state_n = P1Y;
            P1Y:        state_n = P2X;
            P2X:        state_n = P2Y;
            P2Y:        state_n = COMMIT;
            COMMIT:     state_n = PLAY;
            GOAL:       state_n = win ? OVER : SERVE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            {sx, sy, s1x, s1y, s2x, s2y} <= '0;
            acc        <= '0;
            delta_x    <= '0;
            delta_y    <= '0;
            dir_x      <= 1'b0;
            dir_y      <= 1'b0;
            pend_dx    <= '0;
            pend_dy    <= '0;
            pend_dir_x <= 1'b0;
            pend_dir_y <= 1'b0;
            pend_h1    <= 1'b0;
            pend_h2    <= 1'b0;
            puck_reset <= 1'b0;
            hit_1      <= 1'b0;
            hit_2      <= 1'b0;
            score_1    <= '0;
            score_2    <= '0;
            overrun    <= 1'b0;
            concede_2  <= 1'b0;
            serve_cnt  <= '0;
        end else begin
            puck_reset <= 1'b0;
            hit_1      <= 1'b0;
            hit_2      <= 1'b0;
            if (busy && bus.tick) overrun <= 1'b1;
            case (state)
                IDLE, OVER: if (bus.start) begin
                    score_1    <= '0;
                    score_2    <= '0;
                    overrun    <= 1'b0;
                    puck_reset <= 1'b1;
                    serve_cnt  <= '0;
                end
                SERVE: if (bus.tick) begin
                    if (serve_cnt == SERVE_LAST) begin
                        serve_cnt <= '0;
                        delta_x   <= SERVE_DX;
                        delta_y   <= SERVE_DY;
                        // Serve toward whoever conceded the last goal
                        dir_x     <= concede_2;
                        dir_y     <= 1'b1;
                    end else begin
                        serve_cnt <= serve_cnt + 5'd1;
                    end
                end
                PLAY: if (bus.tick) begin
                    sx  <= bus.puck_x;
                    sy  <= bus.puck_y;
                    s1x <= bus.dot_x_1;
                    s1y <= bus.dot_y_1;
                    s2x <= bus.dot_x_2;
                    s2y <= bus.dot_y_2;
                end
                WALL: begin
                    if (goal_l || goal_r) begin
                        if (goal_l) score_2 <= score_2 + 4'd1;
                        else        score_1 <= score_1 + 4'd1;
                        concede_2  <= goal_r;
                        delta_x    <= '0;
                        delta_y    <= '0;
                        puck_reset <= 1'b1;
                    end
                    pend_dir_x <= left_touch ? 1'b1 : (right_touch ? 1'b0 : dir_x);
                    pend_dir_y <= (sy <= Y_TOP) ? 1'b1 : ((sy >= Y_BOT) ? 1'b0 : dir_y);
                    pend_dx    <= delta_x;
                    pend_dy    <= delta_y;
                    pend_h1    <= 1'b0;
                    pend_h2    <= 1'b0;
                end
                P1X, P2X: acc <= {1'b0, sq};
                P1Y: if (contact) begin
                    pend_dir_x <= sx >= s1x;
                    pend_dir_y <= sy >= s1y;
                    pend_dx    <= sat_inc(delta_x);
                    pend_dy    <= sat_inc(delta_y);
                    pend_h1    <= 1'b1;
                end
                P2Y: if (contact && !pend_h1) begin
                    pend_dir_x <= sx >= s2x;
                    pend_dir_y <= sy >= s2y;
                    pend_dx    <= sat_inc(delta_x);
                    pend_dy    <= sat_inc(delta_y);
                    pend_h2    <= 1'b1;
                end
                COMMIT: begin
                    dir_x   <= pend_dir_x;
                    dir_y   <= pend_dir_y;
                    delta_x <= pend_dx;
                    delta_y <= pend_dy;
                    hit_1   <= pend_h1;
                    hit_2   <= pend_h2;
                end
                GOAL: serve_cnt <= '0;
                default: ;
            endcase
        end
    end

    assign bus.delta_x    = delta_x;
    assign bus.delta_y    = delta_y;
    assign bus.dir_x      = dir_x;
    assign bus.dir_y      = dir_y;
    assign bus.puck_reset = puck_reset;
    assign bus.score_1    = score_1;
    assign bus.score_2    = score_2;
    assign bus.hit_1      = hit_1;
    assign bus.hit_2      = hit_2;
    assign bus.game_over  = (state == OVER);
    assign bus.busy       = busy;
    assign bus.overrun    = overrun;
endmodule

// File: tb/tb_puck_ctrl.sv
// tb/tb_puck_ctrl.sv - self-checking bench for puck_ctrl with a behavioural game model
module tb_puck_ctrl;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    puck_ctrl_if bus();
    puck_ctrl dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_EVAL = 3, M_GOAL = 4, M_OVER = 5;

    // Behavioural model: game phase plus the outcome of the tick being evaluated
    int m_mode, m_age, m_scnt, m_dx, m_dy, m_s1, m_s2;
    bit m_con2, m_dirx, m_diry, m_pr, m_h1, m_h2, m_ovr;
    int r_goal, r_dx, r_dy;
    bit r_dirx, r_diry, r_h1, r_h2;

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_age = 0; m_scnt = 0; m_dx = 0; m_dy = 0; m_s1 = 0; m_s2 = 0;
        m_con2 = 0; m_dirx = 0; m_diry = 0; m_pr = 0; m_h1 = 0; m_h2 = 0; m_ovr = 0;
    endtask

    task automatic predict();
        int px, py, ax, ay, bx, by;
        bit left, right, ing;
        px = bus.puck_x;  py = bus.puck_y;
        ax = bus.dot_x_1; ay = bus.dot_y_1;
        bx = bus.dot_x_2; by = bus.dot_y_2;
        left  = (px - 10 <= 194);
        right = (px + 10 >= 737);
        ing   = (py >= 222) && (py <= 322);
        r_goal = (left && ing) ? 1 : ((right && ing) ? 2 : 0);
        r_dirx = left ? 1'b1 : (right ? 1'b0 : m_dirx);
        r_diry = (py - 10 <= 71) ? 1'b1 : ((py + 10 >= 473) ? 1'b0 : m_diry);
        r_dx = m_dx; r_dy = m_dy; r_h1 = 0; r_h2 = 0;
        if ((px - ax) * (px - ax) + (py - ay) * (py - ay) < 625) begin
            r_dirx = (px >= ax); r_diry = (py >= ay); r_h1 = 1;
            r_dx = (m_dx < 15) ? m_dx + 1 : 15; r_dy = (m_dy < 15) ? m_dy + 1 : 15;
        end else if ((px - bx) * (px - bx) + (py - by) * (py - by) < 625) begin
            r_dirx = (px >= bx); r_diry = (py >= by); r_h2 = 1;
            r_dx = (m_dx < 15) ? m_dx + 1 : 15; r_dy = (m_dy < 15) ? m_dy + 1 : 15;
        end
    endtask

    task automatic model_step();
        m_pr = 0; m_h1 = 0; m_h2 = 0;
        case (m_mode)
            M_IDLE, M_OVER: if (bus.start) begin
                m_s1 = 0; m_s2 = 0; m_ovr = 0; m_pr = 1; m_scnt = 0; m_mode = M_SERVE;
            end
            M_SERVE: if (bus.tick) begin
                m_scnt++;
                if (m_scnt == 30) begin
                    m_dx = 3; m_dy = 2; m_dirx = m_con2; m_diry = 1; m_scnt = 0; m_mode = M_PLAY;
                end
            end
            M_PLAY: if (bus.tick) begin
                predict(); m_age = 1; m_mode = M_EVAL;
            end
            M_EVAL: begin
                if (bus.tick) m_ovr = 1;
                if (m_age == 1 && r_goal != 0) begin
                    if (r_goal == 1) m_s2++; else m_s1++;
                    m_con2 = (r_goal == 2);
                    m_dx = 0; m_dy = 0; m_pr = 1; m_mode = M_GOAL;
                end else if (m_age == 6) begin
                    m_dirx = r_dirx; m_diry = r_diry; m_dx = r_dx; m_dy = r_dy;
                    m_h1 = r_h1; m_h2 = r_h2; m_mode = M_PLAY;
                end else begin
                    m_age++;
                end
            end
            M_GOAL: begin
                m_scnt = 0;
                m_mode = (m_s1 == 7 || m_s2 == 7) ? M_OVER : M_SERVE;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge clr_n);
            if (!clr_n) model_reset();
            else        model_step();
        end
    end

    // Compare every output against the model on every cycle out of reset
    initial begin
        logic [23:0] got, exp;
        forever begin
            @(negedge clk);
            if (clr_n) begin
                got = {bus.delta_x, bus.delta_y, bus.dir_x, bus.dir_y, bus.puck_reset,
                       bus.score_1, bus.score_2, bus.hit_1, bus.hit_2, bus.game_over,
                       bus.busy, bus.overrun};
                exp = {4'(m_dx), 4'(m_dy), m_dirx, m_diry, m_pr, 4'(m_s1), 4'(m_s2),
                       m_h1, m_h2, (m_mode == M_OVER), (m_mode == M_EVAL), m_ovr};
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL model_cmp: got %h expected %h at %0t", got, exp, $time);
                end
            end
        end
    end

    task automatic set_puck(input int x, input int y);
        bus.puck_x = 10'(x); bus.puck_y = 10'(y);
    endtask

    task automatic set_dots(input int x1, input int y1, input int x2, input int y2);
        bus.dot_x_1 = 10'(x1); bus.dot_y_1 = 10'(y1);
        bus.dot_x_2 = 10'(x2); bus.dot_y_2 = 10'(y2);
    endtask

    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1; @(negedge clk);
            bus.tick = 1'b0; @(negedge clk);
        end
    endtask

    // Accepted tick, then check busy through cycles 1..6; returns in cycle 7
    task automatic run_eval();
        bus.tick = 1'b1; @(negedge clk);
        bus.tick = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("busy_c%0d", c), bus.busy, 1);
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        #2 clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick = 1'b0; bus.start = 1'b0;
        set_puck(400, 200); set_dots(700, 400, 600, 400);
        repeat (3) @(negedge clk);
        chk("rst_delta_x", bus.delta_x, 0);
        chk("rst_score_1", bus.score_1, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_game_over", bus.game_over, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_puck_reset", bus.puck_reset, 0);
        clr_n = 1'b1;
        @(negedge clk);

        bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
        chk("start_puck_reset", bus.puck_reset, 1);
        @(negedge clk);
        chk("puck_reset_pulse_end", bus.puck_reset, 0);
        serve(29);
        chk("serve_speed_zero", bus.delta_x, 0);
        serve(1);
        chk("serve_dx", bus.delta_x, 3);
        chk("serve_dy", bus.delta_y, 2);
        chk("serve_dir_x_p1", bus.dir_x, 0);
        chk("serve_dir_y", bus.dir_y, 1);

        // Paddle 1 contact
        set_puck(300, 100); set_dots(290, 90, 600, 400);
        run_eval();
        chk("p1_hit_1", bus.hit_1, 1);
        chk("p1_hit_2", bus.hit_2, 0);
        chk("p1_dir_x", bus.dir_x, 1);
        chk("p1_dir_y", bus.dir_y, 1);
        chk("p1_dx", bus.delta_x, 4);
        chk("p1_dy", bus.delta_y, 3);

        // Open field: nothing changes
        set_puck(400, 200); set_dots(700, 400, 600, 400);
        run_eval();
        chk("free_dx", bus.delta_x, 4);
        chk("free_dir_x", bus.dir_x, 1);
        chk("free_dir_y", bus.dir_y, 1);
        chk("free_busy_c7", bus.busy, 0);

        // Bottom wall
        set_puck(300, 466);
        run_eval();
        chk("wall_dir_y", bus.dir_y, 0);
        chk("wall_dy", bus.delta_y, 3);

        // Overrun: second tick three cycles after the first
        set_puck(400, 200);
        bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
        @(negedge clk); @(negedge clk);
        bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
        chk("overrun_set", bus.overrun, 1);
        repeat (3) @(negedge clk);
        chk("overrun_busy_c7", bus.busy, 0);
        @(negedge clk);
        chk("overrun_busy_c8", bus.busy, 0);

        // Right goal
        set_puck(730, 300);
        bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
        @(negedge clk);
        chk("goal_score_1", bus.score_1, 1);
        chk("goal_puck_reset", bus.puck_reset, 1);
        chk("goal_dx", bus.delta_x, 0);
        set_puck(400, 200);
        @(negedge clk);
        serve(29);
        chk("goal_serve_hold", bus.delta_x, 0);
        serve(1);
        chk("goal_serve_dir_x", bus.dir_x, 1);
        chk("goal_serve_dx", bus.delta_x, 3);

        // Reset in the middle of a paddle evaluation
        set_puck(300, 100); set_dots(290, 90, 600, 400);
        bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
        @(negedge clk); @(negedge clk);
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_hit_after_rst", int'(bus.hit_1 | bus.hit_2 | bus.puck_reset), 0);
        end
        chk("rst_mid_busy", bus.busy, 0);

        // Randomised play checked only by the model
        for (int i = 0; i < 3000; i++) begin
            int px, py;
            case ($urandom_range(0, 3))
                0:       px = $urandom_range(188, 215);
                1:       px = $urandom_range(715, 742);
                default: px = $urandom_range(215, 715);
            endcase
            case ($urandom_range(0, 3))
                0:       py = $urandom_range(215, 330);
                1:       py = $urandom_range(60, 90);
                2:       py = $urandom_range(455, 480);
                default: py = $urandom_range(60, 480);
            endcase
            set_puck(px, py);
            if ($urandom_range(0, 1) == 0)
                set_dots(px + $urandom_range(0, 40) - 20, py + $urandom_range(0, 40) - 20,
                         px + $urandom_range(0, 40) - 20, py + $urandom_range(0, 40) - 20);
            else
                set_dots(100, 600, px + $urandom_range(0, 60) - 30, py + $urandom_range(0, 60) - 30);
            bus.tick  = ($urandom_range(0, 2) == 0);
            bus.start = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        bus.tick = 1'b0; bus.start = 1'b0;

        // Player 2 wins on the seventh left-goal entry
        set_dots(700, 400, 600, 400);
        pulse_reset();
        @(negedge clk);
        bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
        for (int g = 1; g <= 7; g++) begin
            set_puck(400, 200);
            serve(30);
            chk("win_serve_dir_x", bus.dir_x, 0);
            set_puck(200, 270);
            bus.tick = 1'b1; @(negedge clk); bus.tick = 1'b0;
            @(negedge clk);
            chk("win_score_2", bus.score_2, g);
            chk("win_puck_reset", bus.puck_reset, 1);
            @(negedge clk);
            chk("win_game_over", bus.game_over, (g == 7) ? 1 : 0);
        end
        chk("over_dx", bus.delta_x, 0);
        bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
        chk("restart_score_2", bus.score_2, 0);
        chk("restart_game_over", bus.game_over, 0);
        chk("restart_puck_reset", bus.puck_reset, 1);
        @(negedge clk);
        set_puck(400, 200);
        serve(30);
        chk("restart_serve_dx", bus.delta_x, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
